// File: rtl/clk_div_pkg.sv
//==== clk_div_pkg -- shared states and helpers for the clock divider (rev 1.0) ====
`default_nettype none

package clk_div_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_SWITCH = 2'd2;
   localparam state_t ST_STOP   = 2'd3;

   localparam int unsigned MIN_DIV  = 2;
   localparam int unsigned DIV_FN_W = 32;

   // Number of source cycles the posedge half-register stays high: N - floor(N/2)
   function automatic logic [DIV_FN_W-1:0] hi_thresh(input logic [DIV_FN_W-1:0] n);
      return n - (n >> 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
//==== clk_div_core -- period counter, 50% duty shaping and tick (rev 1.0) ====
`default_nettype none

module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] div_in,
   output logic             wrap,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] cur_div
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic             run_q, run_d;
   logic             hi_pos_q, hi_pos_d;
   logic             hi_neg_q, hi_neg_d;
   logic             tick_q, tick_d;

   // run is the next-cycle activity, so hi_pos and tick line up with cnt==0
   always_comb begin
      cur_div_d = load ? div_in : cur_div_q;
      run_d     = run;
      wrap      = run_q && (cnt_q == cur_div_q - CNT_W'(1));
      if (!run || !run_q || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      hi_pos_d = run && (DIV_FN_W'(cnt_d) < hi_thresh(DIV_FN_W'(cur_div_d)));
      tick_d   = run && (cnt_d == '0);
      hi_neg_d = hi_pos_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         cur_div_q <= CNT_W'(DEFAULT_DIV);
         run_q     <= 1'b0;
         hi_pos_q  <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cur_div_q <= cur_div_d;
         run_q     <= run_d;
         hi_pos_q  <= hi_pos_d;
         tick_q    <= tick_d;
      end
   end

   // Half-cycle delayed copy; ANDed in for odd divisors to centre the duty cycle
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         hi_neg_q <= 1'b0;
      end else begin
         hi_neg_q <= hi_neg_d;
      end
   end

   assign clk_out = cur_div_q[0] ? (hi_pos_q & hi_neg_q) : hi_pos_q;
   assign tick    = tick_q;
   assign cur_div = cur_div_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//==== clk_div_ctrl -- divisor handshake, enable FSM and boundary-aligned switching (rev 1.0) ====
`default_nettype none

module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             cfg_err_q, cfg_err_d;

   logic             xfer;
   logic             bad_div;
   logic             good_xfer;
   logic             core_run;
   logic             core_load;
   logic [CNT_W-1:0] core_div_in;
   logic             core_wrap;

   assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign xfer      = cfg_valid && cfg_ready;
   assign bad_div   = xfer && (cfg_div < CNT_W'(MIN_DIV));
   assign good_xfer = xfer && !bad_div;

   always_comb begin
      state_d     = state_q;
      pend_div_d  = pend_div_q;
      cfg_err_d   = bad_div;
      core_load   = 1'b0;
      core_div_in = (state_q == ST_IDLE) ? cfg_div : pend_div_q;
      case (state_q)
         ST_IDLE: begin
            core_load = good_xfer;
            if (enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (good_xfer) begin
               pend_div_d = cfg_div;
               state_d    = ST_SWITCH;
            end else if (!enable) begin
               state_d = core_wrap ? ST_IDLE : ST_STOP;
            end
         end
         ST_SWITCH: begin
            // The old period finishes first; the stored divisor takes over at its wrap
            if (core_wrap) begin
               core_load = 1'b1;
               state_d   = enable ? ST_RUN : ST_IDLE;
            end
         end
         ST_STOP: begin
            if (enable) begin
               state_d = ST_RUN;
            end else if (core_wrap) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      core_run = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pend_div_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_div_q <= pend_div_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign cfg_err = cfg_err_q;

   clk_div_core #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .run     (core_run),
      .load    (core_load),
      .div_in  (core_div_in),
      .wrap    (core_wrap),
      .clk_out (clk_out),
      .tick    (tick),
      .cur_div (cur_div)
   );

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//==== tb_clk_div_ctrl -- scoreboard bench for clk_div_ctrl (rev 1.0) ====
`default_nettype none

module tb_clk_div_ctrl;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clk_out;
   logic       tick;
   logic       busy;
   logic [7:0] cur_div;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic       tick;
      logic       h0;
      logic       h1;
      logic       ready;
      logic       busy;
      logic       err;
      logic [7:0] div;
   } exp_t;

   exp_t exp_q[$];

   clk_div_ctrl #(
      .CNT_W       (8),
      .DEFAULT_DIV (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Expected clk_out per half cycle h (0 = first half of the tick cycle)
   function automatic logic hi_half(input int n, input int h);
      if ((n % 2) == 1) return (h >= 1) && (h <= n);
      return h < n;
   endfunction

   function automatic string fmt(input exp_t x);
      return $sformatf("tick=%b clk_out=%b/%b ready=%b busy=%b err=%b div=%0d",
                       x.tick, x.h0, x.h1, x.ready, x.busy, x.err, x.div);
   endfunction

   task automatic push_periods(input int n, input int periods);
      exp_t e;
      for (int p = 0; p < periods; p++) begin
         for (int c = 0; c < n; c++) begin
            e.tick  = (c == 0);
            e.h0    = hi_half(n, 2 * c);
            e.h1    = hi_half(n, 2 * c + 1);
            e.ready = 1'b1;
            e.busy  = 1'b1;
            e.err   = 1'b0;
            e.div   = 8'(n);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_idle(input int cycles, input int div);
      exp_t e;
      for (int c = 0; c < cycles; c++) begin
         e = '{tick: 1'b0, h0: 1'b0, h1: 1'b0, ready: 1'b1, busy: 1'b0, err: 1'b0, div: 8'(div)};
         exp_q.push_back(e);
      end
   endtask

   task automatic sample(output exp_t o);
      @(posedge clk);
      #1;
      o.tick  = tick;
      o.h0    = clk_out;
      o.ready = cfg_ready;
      o.busy  = busy;
      o.err   = cfg_err;
      o.div   = cur_div;
      @(negedge clk);
      #1;
      o.h1 = clk_out;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t o, e;
      int i = 0;
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      push_idle(3, 3);
      while (exp_q.size() > 0) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL reset[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         i++;
      end
   endtask

   task automatic test_even();
      exp_t o, e;
      int i = 0;
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      tests_run++;
      if ({cur_div, busy, clk_out, cfg_ready} !== {8'd4, 1'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL idle_load got div=%0d busy=%b clk_out=%b ready=%b exp div=4 busy=0 clk_out=0 ready=1",
                  cur_div, busy, clk_out, cfg_ready);
      end
      enable = 1'b1;
      push_periods(4, 3);
      while (exp_q.size() > 0) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL even_n4[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         i++;
      end
   endtask

   task automatic test_odd();
      exp_t o, e;
      int i = 0;
      do_reset();
      enable = 1'b1;
      push_periods(3, 3);
      while (exp_q.size() > 0) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL odd_n3[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         i++;
      end
   endtask

   task automatic test_switch();
      exp_t o, e;
      int i = 0;
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = 8'd5;
      enable    = 1'b1;
      push_periods(5, 1);
      push_periods(2, 3);
      for (int k = 2; k <= 4; k++) exp_q[k].ready = 1'b0;
      while (exp_q.size() > 0) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL switch_5to2[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         if (i == 0) cfg_valid = 1'b0;
         if (i == 1) begin
            cfg_valid = 1'b1;
            cfg_div   = 8'd2;
         end
         if (i == 2) cfg_valid = 1'b0;
         i++;
      end
   endtask

   task automatic test_bad_div();
      exp_t o, e;
      int i = 0;
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      enable    = 1'b1;
      push_periods(4, 3);
      exp_q[2].err = 1'b1;
      exp_q[5].err = 1'b1;
      while (exp_q.size() > 0) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL bad_div[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         if (i == 0 || i == 2 || i == 5) cfg_valid = 1'b0;
         if (i == 1) begin
            cfg_valid = 1'b1;
            cfg_div   = 8'd1;
         end
         if (i == 4) begin
            cfg_valid = 1'b1;
            cfg_div   = 8'd0;
         end
         i++;
      end
   endtask

   task automatic test_stop();
      exp_t o, e;
      int i = 0;
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      enable    = 1'b1;
      push_periods(4, 1);
      exp_q[2].ready = 1'b0;
      exp_q[3].ready = 1'b0;
      push_idle(2, 4);
      push_periods(4, 2);
      exp_q[8].ready = 1'b0;
      while (exp_q.size() > 0) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL stop_resume[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         if (i == 0) cfg_valid = 1'b0;
         if (i == 1 || i == 7) enable = 1'b0;
         if (i == 5 || i == 8) enable = 1'b1;
         i++;
      end
   endtask

   task automatic test_async_reset();
      exp_t o, e;
      int i = 0;
      do_reset();
      cfg_valid = 1'b1;
      cfg_div   = 8'd4;
      enable    = 1'b1;
      push_periods(4, 1);
      while (exp_q.size() > 2) begin
         sample(o);
         e = exp_q.pop_front();
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL pre_reset[%0d] got %s exp %s", i, fmt(o), fmt(e));
         end
         if (i == 0) cfg_valid = 1'b0;
         i++;
      end
      exp_q.delete();
      reset = 1'b1;
      #1;
      tests_run++;
      if ({clk_out, busy, cfg_ready, tick, cfg_err, cur_div} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3}) begin
         tests_failed++;
         $display("FAIL async_reset got clk_out=%b busy=%b ready=%b tick=%b err=%b div=%0d exp 0 0 1 0 0 3",
                  clk_out, busy, cfg_ready, tick, cfg_err, cur_div);
      end
      enable = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd();
      test_switch();
      test_bad_div();
      test_stop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
